// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux
//  Description : Receive side of a bit-level TDM link. Aligns to the sender's
//                frame_start mark, routes each slot sample into a per-channel
//                shadow register and publishes complete frames in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 1,
  parameter int LOSS_LIMIT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_valid,
  input  logic                         frame_start,
  output logic [CHANNELS*WIDTH-1:0]    dout,
  output logic                         dout_valid,
  output logic [$clog2(CHANNELS)-1:0]  slot,
  output logic                         locked,
  output logic                         sync_err
);

  localparam int SW = $clog2(CHANNELS);
  localparam int MW = $clog2(LOSS_LIMIT + 1);

  localparam logic [SW-1:0] c_slot_first = '0;
  localparam logic [SW-1:0] c_slot_one   = SW'(1);
  localparam logic [SW-1:0] c_slot_last  = SW'(CHANNELS - 1);
  localparam logic [MW-1:0] c_miss_last  = MW'(LOSS_LIMIT - 1);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [SW-1:0]                 r_slot;
  logic [SW-1:0]                 w_slot_nxt;
  logic [MW-1:0]                 r_miss;
  logic [MW-1:0]                 w_miss_nxt;
  logic                          w_store;
  logic [SW-1:0]                 w_store_idx;
  logic                          w_done;
  logic                          w_err;

  logic [WIDTH-1:0]              r_shadow [CHANNELS-1];
  logic [(CHANNELS-1)*WIDTH-1:0] w_shadow_flat;

  logic [CHANNELS*WIDTH-1:0]     r_dout;
  logic                          r_dout_valid;
  logic                          r_sync_err;

  // State, slot pointer and loss counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_slot  <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  // Alignment decisions for the current valid sample
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_miss_nxt  = r_miss;
    w_store     = 1'b0;
    w_store_idx = r_slot;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        S_HUNT: begin
          if (frame_start) begin
            w_store     = 1'b1;
            w_store_idx = c_slot_first;
            w_slot_nxt  = c_slot_one;
            w_miss_nxt  = '0;
            w_state_nxt = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if ((r_slot == c_slot_first) == frame_start) begin
            // Expected position: accept the sample in its own slot
            w_store = 1'b1;
            if (r_slot == c_slot_first) begin
              w_miss_nxt = '0;
            end
            if (r_slot == c_slot_last) begin
              w_slot_nxt = c_slot_first;
              w_done     = 1'b1;
            end else begin
              w_slot_nxt = r_slot + c_slot_one;
            end
          end else if (frame_start) begin
            // Early mark: restart the frame on this sample
            w_err       = 1'b1;
            w_store     = 1'b1;
            w_store_idx = c_slot_first;
            w_slot_nxt  = c_slot_one;
          end else begin
            // Missing mark: flywheel until the loss limit is reached
            w_err = 1'b1;
            if (r_miss == c_miss_last) begin
              w_state_nxt = S_HUNT;
              w_slot_nxt  = c_slot_first;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt  = r_miss + MW'(1);
              w_store     = 1'b1;
              w_store_idx = c_slot_first;
              w_slot_nxt  = c_slot_one;
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_slot_nxt  = c_slot_first;
        end
      endcase
    end
  end

  // Shadow registers hold slots 0..CHANNELS-2; the last slot goes straight to dout
  generate
    for (genvar k = 0; k < CHANNELS - 1; k++) begin : g_shadow
      // Capture the sample routed to this channel
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow[k] <= '0;
        end else if (w_store && (w_store_idx == SW'(k))) begin
          r_shadow[k] <= din;
        end
      end
      assign w_shadow_flat[k*WIDTH +: WIDTH] = r_shadow[k];
    end
  endgenerate

  // Publish a completed frame and the one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_dout_valid <= w_done;
      r_sync_err   <= w_err;
      if (w_done) begin
        r_dout <= {din, w_shadow_flat};
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == S_LOCKED);
  assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux
//  Description : Directed self-checking bench for tdm_demux (4 ch, 1 bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [3:0] dout;
  logic       dout_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks;
  int failures;

  tdm_demux #(
    .CHANNELS   (4),
    .WIDTH      (1),
    .LOSS_LIMIT (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of input, clock it in, then leave the link idle
  task automatic step(input logic v, input logic d, input logic fs);
    din_valid   = v;
    din         = d;
    frame_start = fs;
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic dv, input logic lk, input logic se);
    check({tag, "_dv"}, 32'(dout_valid), 32'(dv));
    check({tag, "_lk"}, 32'(locked), 32'(lk));
    check({tag, "_se"}, 32'(sync_err), 32'(se));
  endtask

  logic [3:0] exp_frame;
  logic       d;

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1: single frame 1,0,1,1 back to back
    step(1, 1, 1);
    check("t1_slot1", 32'(slot), 32'h1);
    check_status("t1_s0", 1'b0, 1'b1, 1'b0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("t1_dv_early", 32'(dout_valid), 32'h0);
    step(1, 1, 0);
    check("t1_dout", 32'(dout), 32'hD);
    check_status("t1_done", 1'b1, 1'b1, 1'b0);
    check("t1_slot_wrap", 32'(slot), 32'h0);
    step(0, 0, 0);
    check("t1_dv_pulse", 32'(dout_valid), 32'h0);

    // 2: frame 0,1,1,0 with two idle cycles between samples
    step(1, 0, 1);
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 1);
      step(0, 0, 0);
      check("t2_slot_hold", 32'(slot), 32'(i));
      check("t2_dout_hold", 32'(dout), 32'hD);
      check("t2_dv_gap", 32'(dout_valid), 32'h0);
      step(1, (i != 3), 0);
    end
    check("t2_dout", 32'(dout), 32'h6);
    check_status("t2_done", 1'b1, 1'b1, 1'b0);

    // 3: early frame_start on slot 2 realigns the frame
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 0, 1);
    check_status("t3_early", 1'b0, 1'b1, 1'b1);
    check("t3_slot", 32'(slot), 32'h1);
    step(1, 1, 0);
    check("t3_se_pulse", 32'(sync_err), 32'h0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("t3_dout", 32'(dout), 32'hA);
    check_status("t3_done", 1'b1, 1'b1, 1'b0);

    // 4: two frames without frame_start drop lock on the second
    step(1, 0, 0);
    check_status("t4_miss1", 1'b0, 1'b1, 1'b1);
    check("t4_slot1", 32'(slot), 32'h1);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    check("t4_dout_fly", 32'(dout), 32'hC);
    check_status("t4_fly", 1'b1, 1'b1, 1'b0);
    step(1, 1, 0);
    check_status("t4_miss2", 1'b0, 1'b0, 1'b1);
    check("t4_slot_hunt", 32'(slot), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      check_status("t4_hunt", 1'b0, 1'b0, 1'b0);
    end
    check("t4_dout_hold", 32'(dout), 32'hC);
    step(1, 0, 1);
    check("t4_relock", 32'(locked), 32'h1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("t4_dout_new", 32'(dout), 32'h2);
    check("t4_dv_new", 32'(dout_valid), 32'h1);

    // 5: reset in the middle of a frame
    step(1, 1, 1);
    step(1, 1, 0);
    rst_n = 1'b0;
    #1;
    check("t5_dout", 32'(dout), 32'h0);
    check("t5_slot", 32'(slot), 32'h0);
    check_status("t5_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      check_status("t5_hunt", 1'b0, 1'b0, 1'b0);
      check("t5_hunt_slot", 32'(slot), 32'h0);
    end
    check("t5_dout_hold", 32'(dout), 32'h0);

    // 6: eight continuous frames of random data
    exp_frame = '0;
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 4; s++) begin
        d = 1'($urandom_range(0, 1));
        exp_frame[s] = d;
        step(1, d, (s == 0));
        check("t6_dv", 32'(dout_valid), 32'(s == 3));
        check("t6_se", 32'(sync_err), 32'h0);
        if (s == 3) begin
          check("t6_dout", 32'(dout), 32'(exp_frame));
        end
      end
    end
    check("t6_locked", 32'(locked), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
